// File: rtl/jtag_debug_sysclk_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : jtag_debug_sysclk_dispatch
//  Description : System-clock side of the multicore JTAG debug path.
//                Synchronises the tck-domain update strobes, captures the
//                scanned DR / virtual IR and issues one-cycle per-core
//                take_action / take_no_action pulses, then optionally waits
//                for a per-core completion ack with a timeout. Sticky error
//                flags report bad core selects, ack timeouts and overruns.
//  Revision    : 1.0 - initial release
// ============================================================================
module jtag_debug_sysclk_dispatch #(
    parameter int DR_W        = 38,
    parameter int IR_W        = 2,
    parameter int N_CORES     = 4,
    parameter int CSEL_W      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           vs_udr,
    input  logic                           vs_uir,
    input  logic [IR_W-1:0]                ir_in,
    input  logic [DR_W-1:0]                sr,
    input  logic [N_CORES-1:0]             core_ack,
    input  logic                           status_clr,
    output logic [DR_W-1:0]                jdo,
    output logic [IR_W-1:0]                ir_q,
    output logic [N_CORES*(2**IR_W)-1:0]   take_action,
    output logic [N_CORES*(2**IR_W)-1:0]   take_no_action,
    output logic                           busy,
    output logic                           sel_err,
    output logic                           timeout,
    output logic                           overrun
);

    localparam int          c_NPULSE  = N_CORES * (2**IR_W);
    localparam int          c_IDX_W   = CSEL_W + IR_W;
    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

    localparam logic [1:0] c_S_IDLE     = 2'd0;
    localparam logic [1:0] c_S_CAPTURE  = 2'd1;
    localparam logic [1:0] c_S_DISPATCH = 2'd2;
    localparam logic [1:0] c_S_WAIT_ACK = 2'd3;

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_last;
    logic                   r_uir_last;
    logic                   w_udr_p;
    logic                   w_uir_p;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;

    logic [DR_W-1:0]        r_jdo;
    logic [IR_W-1:0]        r_ir_q;
    logic                   r_act;
    logic [CSEL_W-1:0]      r_csel;
    logic [15:0]            r_cnt;
    logic                   r_sel_err;
    logic                   r_timeout;
    logic                   r_overrun;

    logic                   w_act;
    logic [CSEL_W-1:0]      w_csel;
    logic                   w_csel_bad;
    logic                   w_ack;
    logic [15:0]            w_cnt_inc;
    logic                   w_cnt_hit;
    logic [c_IDX_W-1:0]     w_idx;
    logic                   w_sel_err_set;
    logic                   w_timeout_set;
    logic                   w_overrun_set;

    // Command fields live in the captured DR: action bit on top, core select below it
    assign w_act      = r_jdo[DR_W-1];
    assign w_csel     = r_jdo[DR_W-2 -: CSEL_W];
    assign w_csel_bad = ({1'b0, w_csel} >= (CSEL_W+1)'(N_CORES));
    assign w_cnt_inc  = r_cnt + 16'd1;
    assign w_cnt_hit  = (w_cnt_inc == c_TIMEOUT);
    // Pulse index core*2**IR_W + ir is exactly the concatenation {core, ir}
    assign w_idx      = {r_csel, r_ir_q};

    // Edge pulses; chain and edge flops reset high so a level held through reset is not an edge
    assign w_udr_p = r_udr_sync[SYNC_STAGES-1] & ~r_udr_last;
    assign w_uir_p = r_uir_sync[SYNC_STAGES-1] & ~r_uir_last;

    assign w_sel_err_set = (r_state == c_S_CAPTURE) && w_csel_bad;
    assign w_timeout_set = (r_state == c_S_WAIT_ACK) && !w_ack && w_cnt_hit;
    assign w_overrun_set = (r_state != c_S_IDLE) && (w_udr_p || w_uir_p);

    // Select the ack line of the dispatched core; other cores' acks are ignored
    always_comb begin
        w_ack = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (r_csel == CSEL_W'(i)) begin
                w_ack = core_ack[i];
            end
        end
    end

    // Strobe synchronisers and edge-detect flops
    always_ff @(posedge clk) begin
        if (reset) begin
            r_udr_sync <= '1;
            r_uir_sync <= '1;
            r_udr_last <= 1'b1;
            r_uir_last <= 1'b1;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_last <= r_udr_sync[SYNC_STAGES-1];
            r_uir_last <= r_uir_sync[SYNC_STAGES-1];
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_udr_p) begin
                    w_state_nxt = c_S_CAPTURE;
                end
            end
            c_S_CAPTURE: begin
                w_state_nxt = w_csel_bad ? c_S_IDLE : c_S_DISPATCH;
            end
            c_S_DISPATCH: begin
                w_state_nxt = r_act ? c_S_WAIT_ACK : c_S_IDLE;
            end
            c_S_WAIT_ACK: begin
                if (w_ack || w_cnt_hit) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    // Captured DR/IR, registered decode, ack timer and sticky flags (set beats clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_jdo     <= '0;
            r_ir_q    <= '0;
            r_act     <= 1'b0;
            r_csel    <= '0;
            r_cnt     <= '0;
            r_sel_err <= 1'b0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE) begin
                if (w_uir_p) begin
                    r_ir_q <= ir_in;
                end
                if (w_udr_p) begin
                    r_jdo <= sr;
                end
            end
            if (r_state == c_S_CAPTURE) begin
                r_act  <= w_act;
                r_csel <= w_csel;
            end
            if (r_state == c_S_DISPATCH) begin
                r_cnt <= '0;
            end else if ((r_state == c_S_WAIT_ACK) && !w_ack) begin
                r_cnt <= w_cnt_inc;
            end
            r_sel_err <= (r_sel_err & ~status_clr) | w_sel_err_set;
            r_timeout <= (r_timeout & ~status_clr) | w_timeout_set;
            r_overrun <= (r_overrun & ~status_clr) | w_overrun_set;
        end
    end

    // FSM outputs: busy outside IDLE, single one-hot pulse while in DISPATCH
    always_comb begin
        busy           = (r_state != c_S_IDLE);
        take_action    = '0;
        take_no_action = '0;
        for (int i = 0; i < c_NPULSE; i++) begin
            if ((r_state == c_S_DISPATCH) && (w_idx == c_IDX_W'(i))) begin
                take_action[i]    = r_act;
                take_no_action[i] = ~r_act;
            end
        end
    end

    assign jdo     = r_jdo;
    assign ir_q    = r_ir_q;
    assign sel_err = r_sel_err;
    assign timeout = r_timeout;
    assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_jtag_debug_sysclk_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jtag_debug_sysclk_dispatch
//  Description : Directed self-checking bench. Expected pulses are queued with
//                their due cycle when a DR update is driven and compared by a
//                negedge monitor; a second instance with three cores exercises
//                the illegal core-select path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_debug_sysclk_dispatch;

    logic        clk = 1'b0;
    logic        reset;
    logic        vs_udr;
    logic        vs_uir;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic [3:0]  core_ack;
    logic        status_clr;

    logic [37:0] jdo;
    logic [1:0]  ir_q;
    logic [15:0] ta;
    logic [15:0] tna;
    logic        busy, sel_err, timeout, overrun;

    logic [37:0] b_jdo;
    logic [1:0]  b_ir_q;
    logic [11:0] b_ta;
    logic [11:0] b_tna;
    logic        b_busy, b_sel_err, b_timeout, b_overrun;

    always #5 clk = ~clk;

    jtag_debug_sysclk_dispatch #(
        .DR_W(38), .IR_W(2), .N_CORES(4), .CSEL_W(2), .SYNC_STAGES(2), .TIMEOUT(8)
    ) u_dut (
        .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .core_ack(core_ack), .status_clr(status_clr),
        .jdo(jdo), .ir_q(ir_q), .take_action(ta), .take_no_action(tna),
        .busy(busy), .sel_err(sel_err), .timeout(timeout), .overrun(overrun)
    );

    jtag_debug_sysclk_dispatch #(
        .DR_W(38), .IR_W(2), .N_CORES(3), .CSEL_W(2), .SYNC_STAGES(2), .TIMEOUT(8)
    ) u_dut3 (
        .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .core_ack(core_ack[2:0]), .status_clr(status_clr),
        .jdo(b_jdo), .ir_q(b_ir_q), .take_action(b_ta), .take_no_action(b_tna),
        .busy(b_busy), .sel_err(b_sel_err), .timeout(b_timeout), .overrun(b_overrun)
    );

    typedef struct {
        logic [15:0] ta;
        logic [15:0] tna;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          busy_cnt = 0;
    logic        b_watch  = 1'b0;
    logic        b_seen   = 1'b0;
    logic [1:0]  m_ir     = 2'd0;
    logic [37:0] m_jdo    = '0;
    logic [37:0] saved_jdo;

    // Drive after the edge, sample at negedge: a strobe raised here shows up as
    // a pulse on the 5th following negedge (2 sync + edge + capture + decode).
    localparam int c_PULSE_LAT = 5;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_uir(input logic [1:0] v);
        ir_in  = v;
        vs_uir = 1'b1;
        tick(3);
        vs_uir = 1'b0;
        m_ir   = v;
        tick(3);
    endtask

    task automatic dr_write(input logic act, input logic [1:0] csel, input logic [34:0] pl);
        exp_t        e;
        int          idx;
        logic [15:0] v;
        idx   = int'(csel) * 4 + int'(m_ir);
        v     = 16'd1 << idx;
        e.ta  = act ? v : 16'd0;
        e.tna = act ? 16'd0 : v;
        e.due = cyc + c_PULSE_LAT;
        q.push_back(e);
        sr     = {act, csel, pl};
        m_jdo  = {act, csel, pl};
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
    endtask

    // Pulse scoreboard: every negedge the pulse outputs must equal the queued
    // expectation due this cycle, or be all zero otherwise
    initial begin
        exp_t        e;
        logic [15:0] eta, etna;
        forever begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            if (b_watch && (|{b_ta, b_tna})) b_seen = 1'b1;
            eta  = '0;
            etna = '0;
            if (q.size() > 0 && q[0].due == cyc) begin
                e    = q.pop_front();
                eta  = e.ta;
                etna = e.tna;
            end
            n_assert++;
            assert ({ta, tna} === {eta, etna}) else begin
                n_fail++;
                $error("FAIL pulse cyc=%0d observed ta=%0h tna=%0h expected ta=%0h tna=%0h",
                       cyc, ta, tna, eta, etna);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        vs_udr     = 1'b1;
        vs_uir     = 1'b1;
        ir_in      = 2'd0;
        sr         = '0;
        core_ack   = '0;
        status_clr = 1'b0;

        // Reset state, with both strobe levels held high through reset release
        tick(3);
        @(negedge clk);
        chk("rst_jdo", 64'(jdo), 64'd0);
        chk("rst_ir_q", 64'(ir_q), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_flags", 64'({sel_err, timeout, overrun}), 64'd0);
        tick(1);
        reset = 1'b0;
        tick(6);
        @(negedge clk);
        chk("held_busy", 64'(busy), 64'd0);
        chk("held_jdo", 64'(jdo), 64'd0);
        chk("held_ir_q", 64'(ir_q), 64'd0);
        tick(1);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        tick(4);

        // Action to core 2 with ir=1, wrong-core ack ignored, correct ack on cycle 5
        do_uir(2'b01);
        @(negedge clk);
        chk("ir_q_1", 64'(ir_q), 64'd1);
        tick(1);
        dr_write(1'b1, 2'd2, 35'h1_2345_6789);
        tick(2);
        core_ack = 4'b0010;
        tick(1);
        core_ack = 4'b0000;
        tick(2);
        @(negedge clk);
        chk("t1_busy_wait", 64'(busy), 64'd1);
        chk("t1_jdo", 64'(jdo), 64'(m_jdo));
        tick(1);
        core_ack = 4'b0100;
        tick(1);
        core_ack = 4'b0000;
        @(negedge clk);
        chk("t1_busy_done", 64'(busy), 64'd0);
        chk("t1_flags", 64'({sel_err, timeout, overrun}), 64'd0);

        // No-action to core 3, ir=3: two busy cycles; illegal for the 3-core instance
        do_uir(2'b11);
        tick(2);
        busy_cnt = 0;
        b_watch  = 1'b1;
        b_seen   = 1'b0;
        dr_write(1'b0, 2'd3, 35'h0_0000_00A5);
        tick(6);
        b_watch = 1'b0;
        chk("t2_busy_cycles", 64'(busy_cnt), 64'd2);
        chk("t2_sel_err_a", 64'(sel_err), 64'd0);
        chk("b_sel_err", 64'(b_sel_err), 64'd1);
        chk("b_no_pulse", 64'(b_seen), 64'd0);
        chk("b_idle", 64'(b_busy), 64'd0);
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        @(negedge clk);
        chk("b_sel_err_clr", 64'(b_sel_err), 64'd0);

        // Timeout after 8 WAIT_ACK cycles with no ack
        tick(2);
        dr_write(1'b1, 2'd1, 35'h7_0F0F_0F0F);
        tick(9);
        @(negedge clk);
        chk("to_busy_c8", 64'(busy), 64'd1);
        chk("to_flag_c8", 64'(timeout), 64'd0);
        tick(1);
        @(negedge clk);
        chk("to_flag_set", 64'(timeout), 64'd1);
        chk("to_busy_end", 64'(busy), 64'd0);
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        @(negedge clk);
        chk("to_clr", 64'(timeout), 64'd0);

        // Ack arriving on the 8th WAIT_ACK cycle beats the timeout
        tick(2);
        dr_write(1'b1, 2'd1, 35'h0_1111_2222);
        tick(9);
        core_ack = 4'b0010;
        @(negedge clk);
        chk("ack8_busy", 64'(busy), 64'd1);
        tick(1);
        core_ack = 4'b0000;
        @(negedge clk);
        chk("ack8_busy_end", 64'(busy), 64'd0);
        chk("ack8_no_to", 64'(timeout), 64'd0);

        // Overrun: second DR update while waiting, then IR update coinciding with status_clr
        tick(2);
        dr_write(1'b1, 2'd0, 35'h5_5555_5555);
        saved_jdo = m_jdo;
        tick(3);
        sr     = 38'h2A_AAAA_AAAA;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        ir_in  = 2'b00;
        vs_uir = 1'b1;
        @(negedge clk);
        chk("ovr_set", 64'(overrun), 64'd1);
        chk("ovr_jdo_hold", 64'(jdo), 64'(saved_jdo));
        tick(2);
        status_clr = 1'b1;
        tick(1);
        status_clr = 1'b0;
        vs_uir     = 1'b0;
        core_ack   = 4'b0001;
        @(negedge clk);
        chk("ovr_set_beats_clr", 64'(overrun), 64'd1);
        chk("ovr_ir_q_hold", 64'(ir_q), 64'(m_ir));
        tick(1);
        core_ack = 4'b0000;
        @(negedge clk);
        chk("ovr_busy_end", 64'(busy), 64'd0);
        chk("ovr_no_to", 64'(timeout), 64'd0);

        // Reset asserted during WAIT_ACK
        tick(4);
        dr_write(1'b1, 2'd2, 35'h3_0000_0003);
        tick(3);
        @(negedge clk);
        chk("mid_busy", 64'(busy), 64'd1);
        chk("mid_overrun", 64'(overrun), 64'd1);
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        m_ir  = 2'd0;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_flags", 64'({sel_err, timeout, overrun}), 64'd0);
        chk("mid_rst_jdo", 64'(jdo), 64'd0);
        chk("mid_rst_ir_q", 64'(ir_q), 64'd0);
        tick(1);
        core_ack = 4'b0100;
        tick(1);
        core_ack = 4'b0000;
        @(negedge clk);
        chk("late_ack_idle", 64'(busy), 64'd0);

        // Normal operation resumes after reset: no-action to core 1, ir=0
        tick(4);
        dr_write(1'b0, 2'd1, 35'h0_ABCD_0123);
        tick(6);
        @(negedge clk);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_jdo", 64'(jdo), 64'(m_jdo));
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jtag_debug_sysclk_dispatch.md
Name: jtag_debug_sysclk_dispatch

Overview:
Parametrised system-clock-side command dispatcher for the multicore Nios II JTAG debug path.
- Generalises the single-core sysclk stage to N_CORES cores, arbitrary IR/DR widths, a completion handshake, a timeout and sticky error status.
- Synchronises virtual-JTAG update strobes from the tck domain, captures the scanned DR, and decodes IR plus the action bit into one-cycle per-core take_action / take_no_action pulses.
- Sits between the tck-domain shift logic and the per-core OCI/break/trace units.

Parameters:
DR_W, 38, width of scanned data register sr and of jdo
IR_W, 2, width of virtual IR
N_CORES, 4, number of debug targets (1..16)
CSEL_W, 2, core-select field width; must satisfy 2**CSEL_W >= N_CORES
SYNC_STAGES, 2, synchroniser depth for vs_udr/vs_uir (>=2)
TIMEOUT, 255, clk cycles to wait for core_ack before abort (1..65535)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
vs_udr  in  1  update-DR level from tck domain (async)
vs_uir  in  1  update-IR level from tck domain (async)
ir_in  in  IR_W  virtual IR, stable while vs_uir high and afterwards
sr  in  DR_W  tck-domain shift register, stable from vs_udr rise until next shift
core_ack  in  N_CORES  per-core completion strobe
status_clr  in  1  clears sticky flags
jdo  out  DR_W  captured DR contents
ir_q  out  IR_W  captured IR
take_action  out  N_CORES*2**IR_W  one-hot pulse, index core*2**IR_W+ir
take_no_action  out  N_CORES*2**IR_W  one-hot pulse, same indexing
busy  out  1  high in any state other than IDLE
sel_err  out  1  sticky: core index >= N_CORES
timeout  out  1  sticky: ack not received in time
overrun  out  1  sticky: strobe arrived while busy

Behaviour:
- Synchronisers: SYNC_STAGES-flop chain for each strobe, plus one edge-detect flop.
  - All chain and edge flops reset to 1, so a level held high across reset produces no edge.
  - Rising edge of a synchronised strobe gives a 1-cycle udr_p / uir_p.
- Field decode from captured jdo:
  - act = jdo[DR_W-1].
  - csel = jdo[DR_W-2 -: CSEL_W].
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- States: IDLE, CAPTURE, DISPATCH, WAIT_ACK.
- IDLE:
  - uir_p: ir_q <= ir_in; stay IDLE.
  - udr_p: jdo <= sr; go CAPTURE.
  - uir_p and udr_p in the same cycle: capture ir_q first, i.e. ir_q <= ir_in and jdo <= sr together; go CAPTURE.
- CAPTURE: one cycle to register the decode.
  - csel >= N_CORES: set sel_err, no pulse, go IDLE.
  - Otherwise go DISPATCH.
- DISPATCH: exactly one-cycle pulse on bit csel*2**IR_W+ir_q.
  - act=1: pulse take_action, clear counter, go WAIT_ACK.
  - act=0: pulse take_no_action, go IDLE (no ack required).
- WAIT_ACK:
  - core_ack[csel]=1: go IDLE. Acks from other cores are ignored.
  - Else counter++; counter reaching TIMEOUT sets timeout and goes IDLE.
  - Ack on the cycle counter hits TIMEOUT: ack wins, timeout not set.
- Latency: udr_p in cycle n -> jdo valid n+1 -> pulse n+2 (for a legal csel).
- udr_p or uir_p outside IDLE: strobe dropped, overrun set, jdo/ir_q unchanged.
- Sticky flags: status_clr clears all three. A set event in the same cycle as status_clr wins (flag stays 1).
- Reset mid-operation: return to IDLE next cycle; pulses, counter and flags cleared; pending ack forgotten.
- take_action and take_no_action are never both nonzero; at most one bit is high per cycle.

Test Plan:
- N_CORES=4: uir with ir_in=2'b01, then udr with sr[37]=1, sr[36:35]=2 -> take_action[9] pulses 2 cycles after udr_p; core_ack[2] after 5 cycles -> busy drops, no flags set.
- sr[37]=0, csel=3, ir_q=3 -> take_no_action[15] single pulse, no WAIT_ACK, busy high exactly 2 cycles.
- N_CORES=3, csel=3 -> sel_err=1, take_action all zero, IDLE; status_clr -> sel_err=0.
- TIMEOUT=8, act=1, no ack -> timeout=1 after 8 WAIT_ACK cycles; separately, ack exactly on cycle 8 -> timeout stays 0.
- Second vs_udr rise while in WAIT_ACK -> overrun=1, jdo holds first value; status_clr and a new overrun in the same cycle -> overrun stays 1.
- vs_udr held high through reset release -> no pulse; reset asserted during WAIT_ACK -> busy=0 next cycle, all flags 0.
